step_phase_seq: RTL
===================

// Module: step_phase_seq
// PURPOSE
// - Consumes the divided step clock from the clock divider and drives 4 stepper coil phases.
// - Each rising edge of step_clk advances the coil pattern one step (full- or half-step),
//   fwd/rev, for a programmed number of steps; reports busy and a done pulse.
// - Sits between the divider and the motor driver pins; one command per move.
// PARAMETERS
// - CNT_W   16   width of step count / remaining counter
// PORTS
// - clk        in   1      system clock; all logic on posedge clk (divider runs on same clk)
// - res        in   1      reset, synchronous, active-high
// - step_clk   in   1      divided clock from divider (toggle output); rising edge = 1 step
// - start      in   1      1-cycle command strobe; sampled only in IDLE
// - dir        in   1      1 = forward (index+), 0 = reverse (index-); latched at start
// - half       in   1      1 = half-step (8-entry), 0 = full-step two-phase-on; latched at start
// - step_num   in   CNT_W  steps to execute; latched at start
// - abort      in   1      stop move; effective in RUN only
// - phase      out  4      coil drive {A, B, A-, B-}
// - busy       out  1      1 while in RUN
// - done       out  1      1-cycle pulse on normal completion
// - remain     out  CNT_W  steps still to go
// BEHAVIOUR
// - Reset (res=1 at edge): state IDLE, idx=0, phase=4'b0000, busy=0, done=0, remain=0,
//   step_clk_q=0. Reset mid-move aborts immediately, no done.
// - tick = step_clk & ~step_clk_q (comb); step_clk_q <= step_clk every cycle, all states.
// - Table idx->phase: 0:1000 1:1100 2:0100 3:0110 4:0010 5:0011 6:0001 7:1001. idx 3 bits, wraps 7<->0.
// - IDLE: ticks ignored. start=1 and step_num!=0 -> next edge: RUN, busy=1, remain=step_num,
//   dir/half latched; full mode forces idx={idx[2:1],1'b1}; phase <= table(aligned idx)
//   (coils energized before first step). start=1 with step_num==0 -> stay IDLE, done=1 next cycle.
// - RUN, tick=1, abort=0: idx <= idx +/- (half ? 1 : 2); phase <= table(new idx);
//   remain <= remain-1. Visible one cycle after the tick cycle.
// - RUN, tick with remain==1: after update, -> IDLE, busy=0, done=1 for exactly one cycle, remain=0.
// - RUN, abort=1: -> IDLE next edge, busy=0, done=0, remain frozen at current value; abort
//   beats a simultaneous tick (no step taken).
// - start while busy ignored; dir/half/step_num changes during RUN ignored.
// - done never coincides with busy=1; a new start is accepted in the cycle done is high.
// CONFIGURATION
// - STEP_IDLE_OFF_EN defined: on entry to IDLE (done or abort) phase <= 4'b0000 (coils
//   de-energized); idx retained so next move resumes from same position.
// - Not defined: phase holds last pattern in IDLE (holding torque); only reset clears it.
// TESTING
// - Reset, half=1 dir=1 step_num=3, start, 3 ticks -> phase 1000 at RUN entry, then 1100,
//   0100, 0110; done 1 cycle after 3rd tick; busy 0; remain 0.
// - From idx=7, full dir=1 step_num=2 -> aligned idx 7 (1001), then 1100 (idx 1), 0110 (idx 3).
// - Reverse half, idx=0, step_num=2 -> 1001, 0001 (wrap 0->7->6).
// - step_num=5, abort after 2nd tick coincident with 3rd tick -> no 3rd step, IDLE, done=0,
//   remain=3; phase 0000 if STEP_IDLE_OFF_EN else held.
// - start with step_num=0 -> done 1 cycle, busy never 1; start during RUN -> no effect.
// - res asserted mid-move -> next cycle phase=0000, busy=0, remain=0, no done; step_clk held
//   high through reset release -> no step while IDLE.

Source files
------------

// File: rtl/step_phase_seq.sv
// ----------------------------------------------------------------------------
// step_phase_seq
// Stepper coil phase sequencer. Each rising edge of the divided step clock
// advances a 3-bit table index (full-step two-phase-on, or half-step) forward
// or reverse for a commanded number of steps. It drives the 4 coil phases and
// reports busy plus a one-cycle done pulse on normal completion.
//
// Parameters
//   CNT_W     width of the step count / remaining counter
// Ports
//   clk       system clock, all logic on posedge
//   res       synchronous active-high reset
//   step_clk  divided step clock; a rising edge requests one step
//   start     1-cycle command strobe, sampled only in IDLE
//   dir       1 = forward (index+), 0 = reverse; latched at start
//   half      1 = half-step, 0 = full-step; latched at start
//   step_num  steps to execute; latched at start
//   abort     stops the move, effective in RUN only
//   phase     coil drive {A, B, A-, B-}
//   busy      high while a move is running
//   done      1-cycle pulse on normal completion
//   remain    steps still to go
// Build option
//   STEP_IDLE_OFF_EN  de-energize coils (phase = 0000) on every entry to IDLE;
//                     otherwise the last pattern is held for holding torque.
// ----------------------------------------------------------------------------
module step_phase_seq #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             step_clk,
  input  logic             start,
  input  logic             dir,
  input  logic             half,
  input  logic [CNT_W-1:0] step_num,
  input  logic             abort,
  output logic [3:0]       phase,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remain
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       phase_q, phase_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             done_q, done_d;
  logic             dir_q, dir_d;
  logic             half_q, half_d;
  logic             step_clk_q;
  logic             tick;
  logic [2:0]       idx_start;
  logic [2:0]       idx_step;
  logic [2:0]       stride;

  function automatic logic [3:0] phase_lut(input logic [2:0] i);
    logic [3:0] p;
    case (i)
      3'd0:    p = 4'b1000;
      3'd1:    p = 4'b1100;
      3'd2:    p = 4'b0100;
      3'd3:    p = 4'b0110;
      3'd4:    p = 4'b0010;
      3'd5:    p = 4'b0011;
      3'd6:    p = 4'b0001;
      default: p = 4'b1001;
    endcase
    return p;
  endfunction

  assign tick = step_clk & ~step_clk_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    phase_d  = phase_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    dir_d    = dir_q;
    half_d   = half_q;
    // Full-step uses the odd (two-coils-on) entries; stride 2 keeps it there.
    idx_start = half ? idx_q : {idx_q[2:1], 1'b1};
    stride    = half_q ? 3'd1 : 3'd2;
    idx_step  = dir_q ? (idx_q + stride) : (idx_q - stride);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (step_num != '0) begin
            state_d  = RUN;
            remain_d = step_num;
            dir_d    = dir;
            half_d   = half;
            idx_d    = idx_start;
            phase_d  = phase_lut(idx_start);
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
`ifdef STEP_IDLE_OFF_EN
          phase_d = '0;
`endif
        end else if (tick) begin
          idx_d    = idx_step;
          phase_d  = phase_lut(idx_step);
          remain_d = remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
`ifdef STEP_IDLE_OFF_EN
            phase_d = '0;
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      phase_q    <= '0;
      remain_q   <= '0;
      done_q     <= 1'b0;
      dir_q      <= 1'b0;
      half_q     <= 1'b0;
      step_clk_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      remain_q   <= remain_d;
      done_q     <= done_d;
      dir_q      <= dir_d;
      half_q     <= half_d;
      step_clk_q <= step_clk;
    end
  end

  assign phase  = phase_q;
  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign remain = remain_q;

endmodule
